npu_buf_streamer: RTL and testbench

- Downstream neighbour of the NPU memory-mapped buffer wrapper.
- On a start pulse, snapshots the (N+1)*K_SIZE-byte buffer and streams it to the PE core as K_SIZE-byte beats over a valid/ready handshake: one weight beat, then N data beats.
- Reports busy/done back to the register file, so the CPU can rewrite the buffer while a stream is in flight.

---
 rtl/npu_buf_streamer.sv | 167 ++++++++++++++++
 tb/tb_npu_buf_streamer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_buf_streamer.sv
// npu_buf_streamer: snapshots the (N+1)*K_SIZE-entry NPU buffer on start and
// streams it to the PE core as one weight beat followed by N data beats.
// Ports: clk, reset (async, active-low), buf_i (flattened buffer), start_i,
//   clear_i (sync abort), pe_valid_o/pe_ready_i handshake, pe_data_o,
//   pe_wload_o, pe_last_o, busy_o, done_o, stall_cnt_o.
// Optional macro NPU_STREAM_STALL_CNT_EN enables the saturating stall counter;
// when undefined stall_cnt_o is tied to zero.
module npu_buf_streamer #(
    parameter int N          = 10,
    parameter int K_SIZE     = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [(N+1)*K_SIZE*DATA_WIDTH-1:0]    buf_i,
    input  logic                                  start_i,
    input  logic                                  clear_i,
    output logic                                  pe_valid_o,
    input  logic                                  pe_ready_i,
    output logic [K_SIZE*DATA_WIDTH-1:0]          pe_data_o,
    output logic                                  pe_wload_o,
    output logic                                  pe_last_o,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic [15:0]                           stall_cnt_o
);

    localparam int BUFFER_DEPTH = (N + 1) * K_SIZE;
    localparam int BW           = K_SIZE * DATA_WIDTH;
    localparam int SW           = BUFFER_DEPTH * DATA_WIDTH;
    localparam int RW           = $clog2(N + 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WEIGHT = 2'd1,
        DATA   = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [RW-1:0]   cnt, cnt_n;
    logic [SW-1:0]   snap, snap_n;
    logic [RW-1:0]   row_idx;
    logic [BW-1:0]   rows [N+1];
    logic            fire;
    logic            start_ok;

    logic            valid_n;
    logic            wload_n;
    logic            last_n;
    logic            done_n;
    logic [BW-1:0]   data_n;

    assign fire     = pe_valid_o && pe_ready_i;
    assign start_ok = (state == IDLE) && start_i && !clear_i;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        snap_n  = snap;
        done_n  = 1'b0;
        if (clear_i) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        snap_n  = buf_i;
                        state_n = WEIGHT;
                        cnt_n   = '0;
                    end
                end
                WEIGHT: begin
                    if (fire) begin
                        state_n = DATA;
                        cnt_n   = '0;
                    end
                end
                DATA: begin
                    if (fire) begin
                        if (cnt == LAST_ROW) begin
                            state_n = IDLE;
                            cnt_n   = '0;
                            done_n  = 1'b1;
                        end else begin
                            cnt_n = cnt + RW'(1);
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Beat payload is computed from next-state values so every output is a
    // flop; the weight row is row 0, data row r sits at row r+1.
    always_comb begin
        for (int r = 0; r <= N; r++) begin
            rows[r] = snap_n[r*BW +: BW];
        end
    end

    assign row_idx = cnt_n + RW'(1);

    always_comb begin
        valid_n = (state_n != IDLE);
        wload_n = (state_n == WEIGHT);
        last_n  = (state_n == DATA) && (cnt_n == LAST_ROW);
        data_n  = '0;
        if (state_n == WEIGHT) begin
            data_n = rows[0];
        end else if (state_n == DATA) begin
            data_n = rows[row_idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            snap       <= '0;
            pe_valid_o <= 1'b0;
            pe_wload_o <= 1'b0;
            pe_last_o  <= 1'b0;
            pe_data_o  <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            snap       <= snap_n;
            pe_valid_o <= valid_n;
            pe_wload_o <= wload_n;
            pe_last_o  <= last_n;
            pe_data_o  <= data_n;
            busy_o     <= valid_n;
            done_o     <= done_n;
        end
    end

`ifdef NPU_STREAM_STALL_CNT_EN
    logic [15:0] stall_q;

    // Counter holds after done so software can read it back; it is only
    // reset when the next stream is accepted or the stream is aborted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (clear_i || start_ok) begin
            stall_q <= '0;
        end else if (pe_valid_o && !pe_ready_i && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
    assign stall_cnt_o     = '0;
`endif

endmodule

// File: tb/tb_npu_buf_streamer.sv
// tb_npu_buf_streamer: randomized scoreboard bench for npu_buf_streamer.
// Stimulus pushes expected beats; a negedge monitor pops and compares.
module tb_npu_buf_streamer;

    localparam int N  = 10;
    localparam int K  = 3;
    localparam int DW = 8;
    localparam int BD = (N + 1) * K;

    typedef struct {
        logic [K*DW-1:0] data;
        logic            wload;
        logic            last;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [BD*DW-1:0]  buf_i = '0;
    logic              start_i = 1'b0;
    logic              clear_i = 1'b0;
    logic              pe_valid_o;
    logic              pe_ready_i = 1'b0;
    logic [K*DW-1:0]   pe_data_o;
    logic              pe_wload_o;
    logic              pe_last_o;
    logic              busy_o;
    logic              done_o;
    logic [15:0]       stall_cnt_o;

    int checks = 0;
    int failures = 0;

    beat_t q[$];
    logic [7:0] mem [BD];

    int mode = 0;
    int phase = 0;
    int done_seen = 0;
    int stall_model = 0;

    npu_buf_streamer #(.N(N), .K_SIZE(K), .DATA_WIDTH(DW)) dut (
        .clk(clk),
        .reset(reset),
        .buf_i(buf_i),
        .start_i(start_i),
        .clear_i(clear_i),
        .pe_valid_o(pe_valid_o),
        .pe_ready_i(pe_ready_i),
        .pe_data_o(pe_data_o),
        .pe_wload_o(pe_wload_o),
        .pe_last_o(pe_last_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    // Ready pattern: 0 always, 1 repeating 1,0,0,1, 2 random, 3 held low.
    always @(posedge clk) begin
        #2;
        case (mode)
            0: pe_ready_i = 1'b1;
            1: pe_ready_i = ((phase % 4) == 0) || ((phase % 4) == 3);
            2: pe_ready_i = 1'($urandom_range(0, 1));
            default: pe_ready_i = 1'b0;
        endcase
        phase++;
    end

    function automatic logic [BD*DW-1:0] pack_mem();
        logic [BD*DW-1:0] v;
        for (int e = 0; e < BD; e++) v[e*DW +: DW] = mem[e];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected stream from the buffer layout: beat 0 is entries 0..K-1,
    // beat b>0 is data row b-1 at entries K*b .. K*b+K-1.
    task automatic start_stream();
        beat_t b;
        for (int i = 0; i <= N; i++) begin
            for (int j = 0; j < K; j++) b.data[j*DW +: DW] = mem[K*i + j];
            b.wload = (i == 0);
            b.last  = (i == N);
            q.push_back(b);
        end
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done_o && cyc < 500) begin
            tick();
            cyc++;
        end
        if (!done_o) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done after %0d cycles", cyc);
        end
    endtask

    task automatic fill_seq();
        for (int e = 0; e < BD; e++) mem[e] = 8'(e);
        buf_i = pack_mem();
    endtask

    task automatic fill_rand();
        for (int e = 0; e < BD; e++) mem[e] = 8'($urandom);
        buf_i = pack_mem();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(pe_valid_o), 0);
        check({tag, "_busy"}, 32'(busy_o), 0);
        check({tag, "_done"}, 32'(done_o), 0);
        check({tag, "_data"}, 32'(pe_data_o), 0);
        check({tag, "_wload"}, 32'(pe_wload_o), 0);
        check({tag, "_last"}, 32'(pe_last_o), 0);
    endtask

    // Monitor: scoreboard pops, stall stability, done placement, stall count.
    logic             have_stall = 1'b0;
    logic             prev_last  = 1'b0;
    logic [K*DW-1:0]  held_data;
    logic             held_wload;
    logic             held_last;
    beat_t            exp_b;

    always @(negedge clk) begin
        if (!reset) begin
            have_stall  = 1'b0;
            prev_last   = 1'b0;
            stall_model = 0;
        end else begin
            if (have_stall) begin
                checks++;
                if (!pe_valid_o || pe_data_o !== held_data ||
                    pe_wload_o !== held_wload || pe_last_o !== held_last) begin
                    failures++;
                    $display("FAIL stall_hold: got v=%0b d=0x%0h w=%0b l=%0b expected v=1 d=0x%0h w=%0b l=%0b",
                             pe_valid_o, pe_data_o, pe_wload_o, pe_last_o,
                             held_data, held_wload, held_last);
                end
            end
            have_stall = 1'b0;
            if (done_o) begin
                done_seen++;
                check("done_after_last", 32'(prev_last), 1);
                check("done_busy", 32'(busy_o), 0);
`ifdef NPU_STREAM_STALL_CNT_EN
                check("stall_cnt", 32'(stall_cnt_o), 32'(stall_model));
`else
                check("stall_cnt", 32'(stall_cnt_o), 0);
`endif
            end
            prev_last = 1'b0;
            if (clear_i || (start_i && !busy_o)) stall_model = 0;
            if (pe_valid_o && !clear_i) begin
                if (pe_ready_i) begin
                    checks++;
                    if (q.size() == 0) begin
                        failures++;
                        $display("FAIL beat_extra: got d=0x%0h expected no beat", pe_data_o);
                    end else begin
                        exp_b = q.pop_front();
                        if (pe_data_o !== exp_b.data || pe_wload_o !== exp_b.wload ||
                            pe_last_o !== exp_b.last) begin
                            failures++;
                            $display("FAIL beat: got d=0x%0h w=%0b l=%0b expected d=0x%0h w=%0b l=%0b",
                                     pe_data_o, pe_wload_o, pe_last_o,
                                     exp_b.data, exp_b.wload, exp_b.last);
                        end
                    end
                    prev_last = pe_last_o;
                end else begin
                    if (stall_model < 65535) stall_model++;
                    have_stall = 1'b1;
                    held_data  = pe_data_o;
                    held_wload = pe_wload_o;
                    held_last  = pe_last_o;
                end
            end
        end
    end

    int cyc;
    int d0;

    initial begin
        fill_seq();
        #3;
        check_zero("reset");
        check("reset_stall", 32'(stall_cnt_o), 0);
        tick();
        reset = 1'b1;
        tick();

        // basic stream, ready always high
        mode = 0;
        start_stream();
        check("first_beat", 32'(pe_data_o), 32'h020100);
        check("first_wload", 32'(pe_wload_o), 1);
        wait_done(cyc);
        check("done_latency", 32'(cyc + 1), 32'(N + 2));
        tick();

        // backpressure 1,0,0,1
        fill_rand();
        mode = 1;
        phase = 0;
        start_stream();
        wait_done(cyc);
        tick();

        // snapshot isolation under random ready
        fill_rand();
        mode = 2;
        start_stream();
        for (int e = 0; e < BD; e++) mem[e] = 8'hFF;
        buf_i = pack_mem();
        wait_done(cyc);
        tick();

        // start while busy is ignored
        fill_rand();
        d0 = done_seen;
        start_stream();
        repeat (3) tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_done(cyc);
        repeat (15) tick();
        check("busy_start_dones", 32'(done_seen - d0), 1);
        check("busy_start_idle", 32'(busy_o), 0);

        // start in the done cycle
        mode = 0;
        fill_rand();
        start_stream();
        wait_done(cyc);
        fill_rand();
        start_stream();
        check("b2b_valid", 32'(pe_valid_o), 1);
        check("b2b_wload", 32'(pe_wload_o), 1);
        wait_done(cyc);
        tick();

        // abort at beat 5 with ready low
        fill_rand();
        d0 = done_seen;
        start_stream();
        repeat (5) tick();
        mode = 3;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("abort_valid", 32'(pe_valid_o), 0);
        check("abort_busy", 32'(busy_o), 0);
        check("abort_left", 32'(q.size()), 6);
        q.delete();
        repeat (4) tick();
        check("abort_no_done", 32'(done_seen - d0), 0);
        mode = 0;
        fill_rand();
        start_stream();
        wait_done(cyc);
        tick();

        // async reset mid-DATA
        fill_rand();
        start_stream();
        repeat (4) tick();
        #2;
        reset = 1'b0;
        #1;
        check_zero("areset");
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        check_zero("post_reset");
        fill_seq();
        start_stream();
        check("fresh_first", 32'(pe_data_o), 32'h020100);
        wait_done(cyc);
        tick();

        check("queue_empty", 32'(q.size()), 0);
        check("total_dones", 32'(done_seen), 8);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
